// File: rtl/gp_mem_pkg.sv
// Shared definitions for the graphics-processor DRAM path.
// Contents: burst-writer state encoding, DDR2 address-FIFO command codes,
// burst geometry, and a helper that aligns a word address to a burst.
package gp_mem_pkg;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      WRITE0 = 2'd1,
      WRITE1 = 2'd2
   } state_t;

   localparam logic [2:0] AF_CMD_WRITE    = 3'b000;
   localparam logic [2:0] AF_CMD_READ     = 3'b001;
   localparam int         WORDS_PER_BURST = 8;
   localparam int         BEAT_W          = 128;

   // Clears the low address bits so the result is a burst-aligned word address.
   function automatic logic [30:0] burst_align(input logic [30:0] a);
      return a & ~31'(WORDS_PER_BURST - 1);
   endfunction

endpackage

// File: rtl/dram_burst_writer_if.sv
// Bus bundle between the pipeline, the burst writer and the DDR2 FIFOs.
// Signals: word valid/ready/data from the pipeline; af_* command push to the
// address FIFO; wdf_* beat push to the write-data FIFO.
// Modports: master = the burst writer, slave = its environment.
interface dram_burst_writer_if;
   import gp_mem_pkg::*;

   logic              word_valid;
   logic [31:0]       word_data;
   logic              word_ready;

   logic              af_full;
   logic              af_wr_en;
   logic [2:0]        af_cmd_din;
   logic [30:0]       af_addr_din;

   logic              wdf_afull;
   logic              wdf_wr_en;
   logic [BEAT_W-1:0] wdf_din;
   logic [15:0]       wdf_mask_din;

   modport master (
      input  word_valid, word_data, af_full, wdf_afull,
      output word_ready, af_wr_en, af_cmd_din, af_addr_din,
             wdf_wr_en, wdf_din, wdf_mask_din
   );

   modport slave (
      output word_valid, word_data, af_full, wdf_afull,
      input  word_ready, af_wr_en, af_cmd_din, af_addr_din,
             wdf_wr_en, wdf_din, wdf_mask_din
   );

endinterface

// File: rtl/burst_pack_buf.sv
// Eight-slot word buffer for one burst.
// Ports: clk, rst (sync, active-low; clears the slot valid bits only),
// wr_en/wr_slot/wr_data store one word, clr empties the buffer,
// beat_sel picks beat 0 (slots 0-3) or beat 1 (slots 4-7),
// beat_data/beat_mask are the selected beat with empty slots zeroed and masked.
module burst_pack_buf
   import gp_mem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [2:0]        wr_slot,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr,
   input  logic              beat_sel,
   output logic [BEAT_W-1:0] beat_data,
   output logic [15:0]       beat_mask
);

   localparam int LANES = BEAT_W / DATA_W;

   logic [DATA_W-1:0]          slot [WORDS_PER_BURST];
   logic [WORDS_PER_BURST-1:0] vld;

   always_ff @(posedge clk) begin
      if (wr_en) slot[wr_slot] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst)       vld <= '0;
      else if (clr)   vld <= '0;
      else if (wr_en) vld[wr_slot] <= 1'b1;
   end

   // Lane 0 sits in the most significant word of the beat.
   always_comb begin
      beat_data = '0;
      beat_mask = '0;
      for (int l = 0; l < LANES; l++) begin
         if (vld[{beat_sel, 2'(l)}])
            beat_data[BEAT_W-1-DATA_W*l -: DATA_W] = slot[{beat_sel, 2'(l)}];
         else
            beat_mask[15-4*l -: 4] = 4'hF;
      end
   end

endmodule

// File: rtl/dram_burst_writer.sv
// Packs 32-bit pipeline words into 256-bit bursts and writes each burst to the
// DDR2 controller as one address-FIFO command plus two write-data beats.
// Ports: clk, rst (sync, active-low), start/base_addr (rebase and discard),
// flush (write out a partial burst), busy (burst write in progress),
// bursts_done (wrapping burst count), bus (handshake and FIFO signals).
module dram_burst_writer
   import gp_mem_pkg::*;
#(
   parameter int FLUSH_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [30:0] base_addr,
   input  logic        flush,
   output logic        busy,
   output logic [15:0] bursts_done,
   dram_burst_writer_if.master bus
);

   // The idle counter fires on the cycle its next value would hit the limit.
   localparam logic [15:0] TMO_LAST = 16'(FLUSH_TIMEOUT > 0 ? FLUSH_TIMEOUT - 1 : 0);

   state_t            state;
   logic [3:0]        count;
   logic [30:0]       addr;
   logic [15:0]       done_cnt;
   logic [15:0]       tmo;

   logic              ready;
   logic              accept;
   logic [3:0]        cnt_nxt;
   logic              timeout;
   logic              go;
   logic              fire0;
   logic              fire1;
   logic              clr;
   logic [BEAT_W-1:0] beat_data;
   logic [15:0]       beat_mask;

   assign ready   = (state == FILL) & ~start & rst;
   assign accept  = ready & bus.word_valid;
   assign cnt_nxt = count + {3'b000, accept};
   assign timeout = (FLUSH_TIMEOUT != 0) && !accept && (count != 4'd0) && (tmo == TMO_LAST);
   assign go      = (cnt_nxt == 4'(WORDS_PER_BURST)) || ((flush || timeout) && (cnt_nxt != 4'd0));
   assign fire0   = ~bus.af_full & ~bus.wdf_afull;
   assign fire1   = ~bus.wdf_afull;
   assign clr     = ((state == FILL) & start) | ((state == WRITE1) & fire1);

   burst_pack_buf #(.DATA_W(32)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (accept),
      .wr_slot   (count[2:0]),
      .wr_data   (bus.word_data),
      .clr       (clr),
      .beat_sel  (state == WRITE1),
      .beat_data (beat_data),
      .beat_mask (beat_mask)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= FILL;
         count    <= '0;
         addr     <= '0;
         done_cnt <= '0;
         tmo      <= '0;
      end else begin
         case (state)
            FILL: begin
               if (start) begin
                  addr  <= burst_align(base_addr);
                  count <= '0;
                  tmo   <= '0;
               end else begin
                  count <= cnt_nxt;
                  if (go) begin
                     state <= WRITE0;
                     tmo   <= '0;
                  end else if (accept || cnt_nxt == 4'd0) begin
                     tmo <= '0;
                  end else begin
                     tmo <= tmo + 16'd1;
                  end
               end
            end
            WRITE0: begin
               if (fire0) state <= WRITE1;
            end
            WRITE1: begin
               if (fire1) begin
                  state    <= FILL;
                  addr     <= addr + 31'd8;
                  count    <= '0;
                  done_cnt <= done_cnt + 16'd1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   // Everything except the constant command code is forced low during reset.
   assign bus.word_ready   = ready;
   assign bus.af_wr_en     = rst & (state == WRITE0) & fire0;
   assign bus.wdf_wr_en    = rst & (((state == WRITE0) & fire0) | ((state == WRITE1) & fire1));
   assign bus.af_cmd_din   = AF_CMD_WRITE;
   assign bus.af_addr_din  = rst ? addr : '0;
   assign bus.wdf_din      = rst ? beat_data : '0;
   assign bus.wdf_mask_din = rst ? beat_mask : '0;
   assign busy             = rst & (state != FILL);
   assign bursts_done      = rst ? done_cnt : '0;

endmodule

// File: tb/tb_dram_burst_writer.sv
module tb_dram_burst_writer;

   typedef struct {
      int             nwords;
      bit             flush_last;
      logic [0:7][31:0] words;
      logic [127:0]   b0;
      logic [15:0]    m0;
      logic [127:0]   b1;
      logic [15:0]    m1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [30:0] base_addr = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic [15:0] bursts_done;

   logic        start0 = 1'b0;
   logic        flush0 = 1'b0;
   logic [30:0] base0 = '0;
   logic        busy0;
   logic [15:0] bursts_done0;

   dram_burst_writer_if bus();
   dram_burst_writer_if bus0();

   dram_burst_writer #(.FLUSH_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .flush(flush),
      .busy(busy), .bursts_done(bursts_done), .bus(bus)
   );

   dram_burst_writer #(.FLUSH_TIMEOUT(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .base_addr(base0), .flush(flush0),
      .busy(busy0), .bursts_done(bursts_done0), .bus(bus0)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int af_cyc = 0;
   int af0_cnt = 0;
   logic [143:0] beatq[$];
   logic [30:0]  afq[$];
   logic [30:0]  exp_addr;
   logic [15:0]  bd_exp;
   vec_t vt [5];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Outputs are stable at the falling edge; the FIFOs take them on the next rise.
   always @(negedge clk) begin
      if (bus.wdf_wr_en) beatq.push_back({bus.wdf_din, bus.wdf_mask_din});
      if (bus.af_wr_en) begin
         afq.push_back(bus.af_addr_din);
         af_cyc = cyc;
         chk("af_cmd", {141'd0, bus.af_cmd_din}, 144'd0);
      end
      if (bus0.af_wr_en) af0_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_beats(input vec_t v);
      logic [143:0] b;
      chk("beat_count", 144'(beatq.size()), 144'd2);
      chk("cmd_count", 144'(afq.size()), 144'd1);
      if (beatq.size() >= 2 && afq.size() >= 1) begin
         chk("cmd_addr", 144'(afq.pop_front()), 144'(exp_addr));
         b = beatq.pop_front();
         chk("beat0_data", 144'(b[143:16]), 144'(v.b0));
         chk("beat0_mask", 144'(b[15:0]), 144'(v.m0));
         b = beatq.pop_front();
         chk("beat1_data", 144'(b[143:16]), 144'(v.b1));
         chk("beat1_mask", 144'(b[15:0]), 144'(v.m1));
      end
      beatq.delete();
      afq.delete();
      exp_addr = exp_addr + 31'd8;
   endtask

   task automatic run_vec(input vec_t v);
      for (int i = 0; i < v.nwords; i++) begin
         bus.word_valid = 1'b1;
         bus.word_data  = v.words[i];
         flush = v.flush_last && (i == v.nwords - 1);
         settle();
         chk("word_ready", 144'(bus.word_ready), 144'd1);
         tick();
      end
      bus.word_valid = 1'b0;
      bus.word_data  = '0;
      flush = 1'b0;
      if (!v.flush_last && v.nwords < 8) begin
         flush = 1'b1;
         tick();
         flush = 1'b0;
      end
      settle();
      chk("w0_busy", 144'(busy), 144'd1);
      chk("w0_af_wr_en", 144'(bus.af_wr_en), 144'd1);
      chk("w0_ready", 144'(bus.word_ready), 144'd0);
      tick();
      chk("w1_af_wr_en", 144'(bus.af_wr_en), 144'd0);
      chk("w1_wdf_wr_en", 144'(bus.wdf_wr_en), 144'd1);
      tick();
      bd_exp = bd_exp + 16'd1;
      chk("fill_busy", 144'(busy), 144'd0);
      chk("fill_ready", 144'(bus.word_ready), 144'd1);
      chk("bursts_done", 144'(bursts_done), 144'(bd_exp));
      check_beats(v);
   endtask

   initial begin
      vec_t v;
      int   acc;
      int   budget;

      vt[0] = '{nwords: 8, flush_last: 1'b0,
                words: {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8},
                b0: 128'h00000001_00000002_00000003_00000004, m0: 16'h0000,
                b1: 128'h00000005_00000006_00000007_00000008, m1: 16'h0000};
      vt[1] = '{nwords: 3, flush_last: 1'b0,
                words: {32'hA, 32'hB, 32'hC, 160'h0},
                b0: 128'h0000000A_0000000B_0000000C_00000000, m0: 16'h000F,
                b1: 128'h0, m1: 16'hFFFF};
      vt[2] = '{nwords: 8, flush_last: 1'b1,
                words: {32'h30, 32'h31, 32'h32, 32'h33, 32'h34, 32'h35, 32'h36, 32'h37},
                b0: 128'h00000030_00000031_00000032_00000033, m0: 16'h0000,
                b1: 128'h00000034_00000035_00000036_00000037, m1: 16'h0000};
      vt[3] = '{nwords: 5, flush_last: 1'b1,
                words: {32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 96'h0},
                b0: 128'h00000040_00000041_00000042_00000043, m0: 16'h0000,
                b1: 128'h00000044_00000000_00000000_00000000, m1: 16'h0FFF};
      vt[4] = '{nwords: 1, flush_last: 1'b0,
                words: {32'hDEADBEEF, 224'h0},
                b0: 128'hDEADBEEF_00000000_00000000_00000000, m0: 16'h0FFF,
                b1: 128'h0, m1: 16'hFFFF};

      bus.word_valid = 1'b0; bus.word_data = '0; bus.af_full = 1'b0; bus.wdf_afull = 1'b0;
      bus0.word_valid = 1'b0; bus0.word_data = '0; bus0.af_full = 1'b0; bus0.wdf_afull = 1'b0;

      // Reset behaviour
      repeat (3) tick();
      chk("rst_ready", 144'(bus.word_ready), 144'd0);
      chk("rst_busy", 144'(busy), 144'd0);
      chk("rst_bursts", 144'(bursts_done), 144'd0);
      chk("rst_wdf_din", 144'(bus.wdf_din), 144'd0);
      rst = 1'b1;
      settle();
      chk("post_rst_ready", 144'(bus.word_ready), 144'd1);
      chk("post_rst_addr", 144'(bus.af_addr_din), 144'd0);
      chk("post_rst_mask", 144'(bus.wdf_mask_din), 144'hFFFF);

      start = 1'b1; base_addr = 31'h100;
      tick();
      start = 1'b0;
      exp_addr = 31'h100;
      bd_exp = 16'd0;

      for (int i = 0; i < 5; i++) run_vec(vt[i]);

      // Flush of an empty buffer is dropped
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (3) tick();
      chk("empty_flush_cmds", 144'(afq.size()), 144'd0);
      chk("empty_flush_busy", 144'(busy), 144'd0);

      // Backpressure on both FIFOs
      for (int i = 0; i < 8; i++) begin
         bus.word_valid = 1'b1;
         bus.word_data  = 32'h50 + 32'(i);
         if (i == 7) bus.af_full = 1'b1;
         tick();
      end
      bus.word_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall0_af", 144'(bus.af_wr_en), 144'd0);
         chk("stall0_wdf", 144'(bus.wdf_wr_en), 144'd0);
         chk("stall0_data", 144'(bus.wdf_din), 144'(128'h00000050_00000051_00000052_00000053));
         chk("stall0_addr", 144'(bus.af_addr_din), 144'(exp_addr));
         tick();
      end
      bus.af_full = 1'b0;
      settle();
      chk("release0_af", 144'(bus.af_wr_en), 144'd1);
      tick();
      bus.wdf_afull = 1'b1;
      settle();
      for (int i = 0; i < 3; i++) begin
         chk("stall1_wdf", 144'(bus.wdf_wr_en), 144'd0);
         chk("stall1_data", 144'(bus.wdf_din), 144'(128'h00000054_00000055_00000056_00000057));
         chk("stall1_busy", 144'(busy), 144'd1);
         tick();
      end
      bus.wdf_afull = 1'b0;
      settle();
      chk("release1_wdf", 144'(bus.wdf_wr_en), 144'd1);
      tick();
      bd_exp = bd_exp + 16'd1;
      chk("bp_bursts", 144'(bursts_done), 144'(bd_exp));
      v = '{nwords: 8, flush_last: 1'b0, words: '0,
            b0: 128'h00000050_00000051_00000052_00000053, m0: 16'h0,
            b1: 128'h00000054_00000055_00000056_00000057, m1: 16'h0};
      check_beats(v);

      // start with five words buffered discards them; a same-cycle flush is ignored
      for (int i = 0; i < 5; i++) begin
         bus.word_valid = 1'b1;
         bus.word_data  = 32'h60 + 32'(i);
         tick();
      end
      bus.word_valid = 1'b0;
      start = 1'b1; flush = 1'b1; base_addr = 31'h2345;
      settle();
      chk("start_ready", 144'(bus.word_ready), 144'd0);
      tick();
      start = 1'b0; flush = 1'b0;
      repeat (100) tick();
      chk("discard_cmds", 144'(afq.size()), 144'd0);
      chk("discard_beats", 144'(beatq.size()), 144'd0);
      exp_addr = 31'h2340;
      v = '{nwords: 8, flush_last: 1'b0,
            words: {32'h70, 32'h71, 32'h72, 32'h73, 32'h74, 32'h75, 32'h76, 32'h77},
            b0: 128'h00000070_00000071_00000072_00000073, m0: 16'h0,
            b1: 128'h00000074_00000075_00000076_00000077, m1: 16'h0};
      run_vec(v);

      // Idle timeout flush
      bus.word_valid = 1'b1;
      bus.word_data  = 32'h77;
      tick();
      acc = cyc;
      bus.word_valid = 1'b0;
      budget = 200;
      while (beatq.size() < 2 && budget > 0) begin
         tick();
         budget--;
      end
      chk("tmo_latency", 144'(af_cyc - acc), 144'd64);
      tick();
      bd_exp = bd_exp + 16'd1;
      chk("tmo_bursts", 144'(bursts_done), 144'(bd_exp));
      v = '{nwords: 1, flush_last: 1'b0, words: '0,
            b0: 128'h00000077_00000000_00000000_00000000, m0: 16'h0FFF,
            b1: 128'h0, m1: 16'hFFFF};
      check_beats(v);

      // Reset while in WRITE1
      for (int i = 0; i < 8; i++) begin
         bus.word_valid = 1'b1;
         bus.word_data  = 32'h90 + 32'(i);
         tick();
      end
      bus.word_valid = 1'b0;
      tick();
      rst = 1'b0;
      settle();
      chk("rst_w1_wdf", 144'(bus.wdf_wr_en), 144'd0);
      chk("rst_w1_busy", 144'(busy), 144'd0);
      chk("rst_w1_bursts", 144'(bursts_done), 144'd0);
      tick();
      rst = 1'b1;
      settle();
      chk("after_rst_busy", 144'(busy), 144'd0);
      chk("after_rst_bursts", 144'(bursts_done), 144'd0);
      chk("after_rst_ready", 144'(bus.word_ready), 144'd1);
      chk("after_rst_addr", 144'(bus.af_addr_din), 144'd0);
      repeat (10) tick();
      chk("after_rst_beats", 144'(beatq.size()), 144'd1);
      chk("after_rst_cmds", 144'(afq.size()), 144'd1);
      beatq.delete();
      afq.delete();

      // Timeout disabled: one buffered word never gets written
      bus0.word_valid = 1'b1;
      bus0.word_data  = 32'h1234;
      settle();
      chk("t0_ready", 144'(bus0.word_ready), 144'd1);
      tick();
      bus0.word_valid = 1'b0;
      repeat (1100) tick();
      chk("t0_no_write", 144'(af0_cnt), 144'd0);
      chk("t0_busy", 144'(busy0), 144'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/dram_burst_writer.md
# dram_burst_writer

Write-side companion to the graphics-processor DRAM read FIFO. It accepts 32-bit words from the pipeline over a valid/ready handshake and packs eight of them into one 256-bit burst. Each burst is issued to the DDR2 controller as one write command on the address FIFO (af) and two 128-bit beats on the write-data FIFO (wdf). Partial bursts are flushed with byte masks, either on request or after an idle timeout.

## Interface
- FLUSH_TIMEOUT, 64: idle cycles with a partial burst buffered before an automatic flush. 0 disables the timeout.
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  loads base_addr and discards any buffered words. Honored only in FILL.
- base_addr  in  31  word address of the first burst. Bits [2:0] are ignored and treated as 0.
- word_valid  in  1  word_data is valid.
- word_data  in  32  data word.
- word_ready  out  1  block accepts the word this cycle.
- flush  in  1  write out a partial burst. No effect if the buffer is empty.
- af_full  in  1  address FIFO is full.
- af_wr_en  out  1  push a command to the address FIFO.
- af_cmd_din  out  3  command code. Constant 3'b000 (write).
- af_addr_din  out  31  burst word address. Always a multiple of 8.
- wdf_afull  in  1  write-data FIFO is almost full.
- wdf_wr_en  out  1  push one beat to the write-data FIFO.
- wdf_din  out  128  beat data.
- wdf_mask_din  out  16  byte mask. 1 = byte not written.
- busy  out  1  a burst write is in progress (WRITE0/WRITE1).
- bursts_done  out  16  count of completed bursts. Wraps.

## Operation
- States:
  - FILL: collect words.
  - WRITE0: command plus beat 0.
  - WRITE1: beat 1.
- Reset (rst=0 at a clock edge):
  - state ← FILL, count ← 0, addr ← 0, bursts_done ← 0, timeout counter ← 0.
  - All outputs are 0 while rst is low. af_cmd_din is always 3'b000.
- word_ready = (state==FILL) & ~start & rst.
- An accepted word is stored in slot count, then count increments.
- Slot packing:
  - Slot k goes to beat k/4, lane k%4.
  - Lane 0 is bits [127:96], lane 3 is bits [31:0].
- FILL → WRITE0 on either:
  - acceptance of the 8th word, or
  - (flush | timeout) with count>0 after that cycle's acceptance.
- Flush rules:
  - A word accepted in the same cycle as flush is included in the flushed burst.
  - A flush with count==0 after acceptance is dropped.
  - A flush arriving while not in FILL is dropped.
- WRITE0:
  - af_wr_en = wdf_wr_en = ~af_full & ~wdf_afull. Both are asserted together or not at all.
  - af_addr_din = addr.
  - The state advances only when both enables fire.
- WRITE1:
  - wdf_wr_en = ~wdf_afull.
  - When it fires: state → FILL, addr ← addr+8 (wraps mod 2^31), count ← 0, bursts_done++.
- Masks:
  - Each empty slot sets its 4 mask bits to 1, in the lane position matching the data.
  - Empty slots drive data 0.
  - A full burst has mask 0 on both beats.
- Timeout:
  - The counter clears on any accepted word or start, and also whenever count==0.
  - Otherwise it increments in FILL.
  - Reaching FLUSH_TIMEOUT acts as flush.
- start in FILL: addr ← {base_addr[30:3],3'b0}, count ← 0. A pending flush in the same cycle is ignored.
- Reset mid-burst aborts the write. A command already pushed without its second beat is the caller's responsibility.

## Timing
- 8th word accepted at cycle N → WRITE0 at N+1 (command and beat 0 fire if not stalled) → WRITE1 at N+2 → FILL at N+3, with word_ready high at N+3.
- Minimum cost: 10 cycles per 8 words.
- Stalls:
  - af_full or wdf_afull holds the state.
  - Outputs other than the enables stay stable while stalled.
- Outputs are combinational from registered state. There are no combinational paths from word_valid to any output.

## Structure
- Shared package `gp_mem_pkg`, containing:
  - state enum {FILL, WRITE0, WRITE1}.
  - AF_CMD_WRITE=3'b000 and AF_CMD_READ=3'b001.
  - WORDS_PER_BURST=8.
  - BEAT_W=128.
- One natural sub-module, `burst_pack_buf`. It holds the 8×32 slot registers and the valid bits, and produces the beat data and mask for a selected beat.

## Test plan
- Full burst:
  - Stimulus: reset, start with base_addr=0x100, then stream words 0x00000001..0x00000008.
  - Response: one af write at addr 0x100. Beat 0 = 0x00000001_00000002_00000003_00000004, beat 1 = 0x00000005_..._00000008. Both masks 0. bursts_done=1.
- Partial flush:
  - Stimulus: 3 words 0xA, 0xB, 0xC, then flush.
  - Response: beat 0 mask 0x000F, beat 1 mask 0xFFFF, data lane 3 = 0. addr advances by 8.
- Backpressure:
  - Stimulus: hold af_full=1 for 5 cycles during WRITE0, then wdf_afull=1 for 3 cycles in WRITE1.
  - Response: no enable fires while stalled. Exactly one command and two beats total. Data stable throughout.
- Timeout:
  - Stimulus: FLUSH_TIMEOUT=64, 1 word, then idle.
  - Response: flush begins 64 cycles after acceptance, with mask 0x0FFF/0xFFFF. With FLUSH_TIMEOUT=0 there is no write after 1000 cycles.
- Boundary cases:
  - Stimulus: word_valid and flush in the same cycle with count=7.
  - Response: a full burst with mask 0.
  - Stimulus: start with count=5.
  - Response: the words are discarded and no write occurs.
  - Stimulus: rst low during WRITE1.
  - Response: FILL, bursts_done=0, no further wdf writes.
